// File: rtl/fft_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_ctrl_pkg
//  Description : Shared state encoding and config-word helpers for the
//                XFFT frame controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_ctrl_pkg;

   // Input-side sequencer states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONFIG = 2'd1,
      FILL   = 2'd2,
      SKIP   = 2'd3
   } ctrl_state_t;

   // Widest scale schedule (N_FFT = 12) and widest padded config word
   localparam int SCH_MAX_W = 24;
   localparam int CFG_MAX_W = 32;

   // Config tdata width: 1 direction bit + 2 bits per stage, byte padded
   function automatic int cfg_width(input int n_fft);
      return 8 * ((1 + 2 * n_fft + 7) / 8);
   endfunction

   // Config word: scale schedule above a forward-transform bit, zero padded
   function automatic logic [CFG_MAX_W-1:0] make_cfg(input logic [SCH_MAX_W-1:0] sch);
      return {{(CFG_MAX_W - SCH_MAX_W - 1){1'b0}}, sch, 1'b1};
   endfunction

endpackage
`default_nettype wire

// File: rtl/axis_if.sv
`default_nettype none
// ============================================================================
//  Module      : Axis_If
//  Description : Minimal AXI-Stream bundle (data/valid/ready/last).
//  Revision    : 1.0 - initial release
// ============================================================================
interface Axis_If #(
   parameter int DATA_WIDTH = 24
);
   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  ready;
   logic                  last;

   modport Master (output data, output valid, output last, input ready);
   modport Slave  (input data, input valid, input last, output ready);
endinterface
`default_nettype wire

// File: rtl/fft_out_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : fft_out_monitor
//  Description : Tracks the FFT output stream: bin index, completed-frame
//                count and a sticky flag for tlast in the wrong place.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_out_monitor #(
   parameter int N_FFT = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             beat,
   input  logic             beat_last,
   output logic [N_FFT-1:0] bin_index,
   output logic [31:0]      frame_count,
   output logic             err_tlast
);

   localparam logic [N_FFT-1:0] LAST_BIN = '1;

   // Count beats and frames; bin_index free-runs and is never resynchronised
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bin_index   <= '0;
         frame_count <= '0;
         err_tlast   <= 1'b0;
      end else if (beat) begin
         bin_index <= bin_index + N_FFT'(1);
         if (beat_last)
            frame_count <= frame_count + 32'd1;
         if (beat_last != (bin_index == LAST_BIN))
            err_tlast <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fft_frame_ctrl
//  Description : Cuts a continuous sample stream into 2^N_FFT frames for the
//                burst XFFT core, sends config words at frame boundaries,
//                optionally skips frames, and monitors the FFT output.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_ctrl
   import fft_ctrl_pkg::*;
#(
   parameter int N_FFT      = 9,
   parameter int DATA_WIDTH = 24,
   parameter int SKIP_WIDTH = 16,
   parameter int CFG_WIDTH  = cfg_width(N_FFT)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [SKIP_WIDTH-1:0] skip_frames,
   input  logic [2*N_FFT-1:0]    scale_sch,
   input  logic                  cfg_update,
   Axis_If.Slave                 samples_in,
   Axis_If.Master                fft_data,
   output logic [CFG_WIDTH-1:0]  fft_cfg_tdata,
   output logic                  fft_cfg_tvalid,
   input  logic                  fft_cfg_tready,
   Axis_If.Slave                 fft_result,
   Axis_If.Master                spec_out,
   output logic [N_FFT-1:0]      bin_index,
   output logic [31:0]           frame_count,
   output logic                  busy,
   output logic                  err_tlast
);

   localparam logic [N_FFT-1:0]      LAST_IDX = '1;
   localparam logic [SKIP_WIDTH-1:0] SKIP_ONE = SKIP_WIDTH'(1);

   ctrl_state_t           state;
   ctrl_state_t           nxt;
   logic [N_FFT-1:0]      sample_cnt;
   logic [SKIP_WIDTH-1:0] skip_cnt;
   logic                  cfg_pending;

   logic [DATA_WIDTH-1:0] sample_data;
   logic [DATA_WIDTH-1:0] result_data;
   logic [CFG_MAX_W-1:0]  cfg_word;
   logic                  in_fill;
   logic                  fill_hs;
   logic                  skip_hs;
   logic                  cnt_wrap;
   logic                  boundary_cfg;

   assign in_fill  = (state == FILL);
   assign cnt_wrap = (sample_cnt == LAST_IDX);
   assign fill_hs  = in_fill & samples_in.valid & fft_data.ready;
   assign skip_hs  = (state == SKIP) & samples_in.valid;
   assign cfg_word = make_cfg(SCH_MAX_W'(scale_sch));

   // Only FILL forwards samples; every other state drains upstream freely
   assign sample_data      = samples_in.data;
   assign fft_data.data    = sample_data;
   assign fft_data.valid   = in_fill & samples_in.valid;
   assign fft_data.last    = in_fill & cnt_wrap;
   assign samples_in.ready = in_fill ? fft_data.ready : 1'b1;

   // Output stream is a pure pass-through; the monitor only observes it
   assign result_data      = fft_result.data;
   assign spec_out.data    = result_data;
   assign spec_out.valid   = fft_result.valid;
   assign spec_out.last    = fft_result.last;
   assign fft_result.ready = spec_out.ready;

   assign busy = (state != IDLE);

   // Where to go once a frame or skip period is fully done
   assign boundary_cfg = cfg_pending;

   // Next-state decision; frames and skip periods are never cut short
   always_comb begin
      nxt = state;
      case (state)
         IDLE:
            if (enable)
               nxt = boundary_cfg ? CONFIG : FILL;
         CONFIG:
            if (fft_cfg_tvalid && fft_cfg_tready)
               nxt = FILL;
         FILL:
            if (fill_hs && cnt_wrap) begin
               if (!enable)
                  nxt = IDLE;
               else if (skip_frames != '0)
                  nxt = SKIP;
               else
                  nxt = boundary_cfg ? CONFIG : FILL;
            end
         SKIP:
            if (skip_hs && cnt_wrap && (skip_cnt == SKIP_ONE)) begin
               if (!enable)
                  nxt = IDLE;
               else
                  nxt = boundary_cfg ? CONFIG : FILL;
            end
         default:
            nxt = IDLE;
      endcase
   end

   // Sequencer registers, counters and the registered config channel
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         sample_cnt     <= '0;
         skip_cnt       <= '0;
         cfg_pending    <= 1'b1;
         fft_cfg_tdata  <= '0;
         fft_cfg_tvalid <= 1'b0;
      end else begin
         state          <= nxt;
         fft_cfg_tvalid <= (nxt == CONFIG);

         // Entering CONFIG consumes the request unless a new one arrives now
         if ((nxt == CONFIG) && (state != CONFIG)) begin
            fft_cfg_tdata <= CFG_WIDTH'(cfg_word);
            cfg_pending   <= cfg_update;
         end else if (cfg_update) begin
            cfg_pending <= 1'b1;
         end

         if (fill_hs || skip_hs) begin
            if (cnt_wrap)
               sample_cnt <= '0;
            else
               sample_cnt <= sample_cnt + N_FFT'(1);
         end

         if (fill_hs && cnt_wrap && (nxt == SKIP))
            skip_cnt <= skip_frames;
         else if (skip_hs && cnt_wrap)
            skip_cnt <= skip_cnt - SKIP_ONE;

         if (state == CONFIG && nxt == FILL)
            sample_cnt <= '0;
      end
   end

   fft_out_monitor #(
      .N_FFT (N_FFT)
   ) u_out_monitor (
      .clk         (clk),
      .reset       (reset),
      .beat        (fft_result.valid & spec_out.ready),
      .beat_last   (fft_result.last),
      .bin_index   (bin_index),
      .frame_count (frame_count),
      .err_tlast   (err_tlast)
   );

endmodule
`default_nettype wire

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Sequences the radix-2 burst XFFT core.
- Gates a continuous sample stream into exact 2^N_FFT-sample frames, generating tlast on the last sample of each frame.
- Issues the config word (forward transform plus scale schedule) at frame boundaries, and optionally skips whole frames to reduce the spectrum rate.
- Monitors the FFT output stream, providing a bin index, a frame count and a sticky tlast-error flag.
- Sits between the ADC sample stream and the FFT wrapper's data/config channels, and between the FFT output and the magnitude/averaging stage.

Parameters:
- N_FFT, 9, log2 of the FFT length (valid range 9..12).
- DATA_WIDTH, 24, width of the FFT data channel tdata.
- SKIP_WIDTH, 16, width of the skip_frames input.
- CFG_WIDTH, 8*((1+2*N_FFT+7)/8), width of the config tdata (byte-padded).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; frames are captured while this is high.
- skip_frames  in  SKIP_WIDTH  number of whole frames to discard after each captured frame.
- scale_sch  in  2*N_FFT  scale schedule, applied at the next config.
- cfg_update  in  1  single-cycle request to resend the config word.
- samples_in  Axis_If.Slave  DATA_WIDTH  raw sample stream; its last is ignored.
- fft_data  Axis_If.Master  DATA_WIDTH  to the FFT data input.
- fft_cfg_tdata  out  CFG_WIDTH  config word.
- fft_cfg_tvalid  out  1  config valid.
- fft_cfg_tready  in  1  config ready.
- fft_result  Axis_If.Slave  DATA_WIDTH  from the FFT output.
- spec_out  Axis_If.Master  DATA_WIDTH  pass-through of fft_result.
- bin_index  out  N_FFT  index of the current spec_out beat.
- frame_count  out  32  number of completed output frames.
- busy  out  1  high when the state is not IDLE.
- err_tlast  out  1  sticky tlast mismatch flag.

Behaviour:
- Reset (async, active-high):
  - State IDLE; sample counter, skip counter, bin_index and frame_count all 0.
  - err_tlast 0, fft_cfg_tvalid 0, cfg_pending 1.
- State IDLE:
  - samples_in.ready=1 (samples are discarded, upstream never stalls); fft_data.valid=0.
  - When enable=1: go to CONFIG if cfg_pending, else go to FILL.
- State CONFIG:
  - On entry, latch fft_cfg_tdata = zero-extended {scale_sch, 1'b1} and clear cfg_pending.
  - fft_cfg_tvalid=1 and tdata held stable until fft_cfg_tready.
  - On the handshake, go to FILL with the sample counter at 0. samples_in.ready=1 (discard).
- State FILL:
  - fft_data.data/valid equal samples_in data/valid; samples_in.ready equals fft_data.ready. All combinational, zero latency.
  - fft_data.last=1 when the sample counter equals 2^N_FFT-1.
  - The counter increments on each fft_data handshake.
  - On the handshake with last, the counter wraps to 0 and the next state is chosen in priority order:
    - IDLE if enable=0;
    - else SKIP if skip_frames!=0, latching skip_frames into the skip counter;
    - else CONFIG if cfg_pending;
    - else FILL.
- State SKIP:
  - samples_in.ready=1; every samples_in handshake increments the sample counter.
  - At a counter wrap, the skip counter decrements.
  - When it reaches 0: go to IDLE if enable=0, else CONFIG if cfg_pending, else FILL.
- cfg_update:
  - Sets cfg_pending in any state, including CONFIG; a request in CONFIG causes one further config at the next boundary.
  - Never interrupts FILL.
  - A simultaneous entry to CONFIG plus cfg_update leaves cfg_pending=1.
- enable deassert: never truncates a frame. FILL completes the full 2^N_FFT samples; SKIP completes the current skip period.
- Output side:
  - spec_out mirrors fft_result combinationally (data, valid, last; ready back-propagated).
  - bin_index increments on each spec_out handshake and wraps from 2^N_FFT-1 to 0.
  - frame_count increments (mod 2^32) on a handshake with last=1.
  - err_tlast is set on any handshake where last != (bin_index==2^N_FFT-1); it is cleared only by reset. bin_index is not resynchronised.
- The output side is independent of the input FSM state.
- busy = (state != IDLE).

Decomposition:
- fft_ctrl_pkg: state enum {IDLE, CONFIG, FILL, SKIP}, a function for CFG_WIDTH, and a function assembling the config word.
- Sub-module fft_out_monitor: bin counter, frame counter and tlast check on the output stream, instantiated once.

Test Plan:
- reset, enable=1, skip=0, fft ready=1, continuous samples -> exactly one config handshake with tdata={scale_sch,1}; last on samples 511, 1023, ...; no gaps.
- skip_frames=2 -> frames 0, 3, 6 forwarded; 1024 samples discarded between frames; fft_data.valid low throughout SKIP.
- cfg_update pulsed mid-FILL (sample 200) -> config sent only after sample 511; pulse during CONFIG -> two configs back-to-back at successive boundaries.
- enable dropped at sample 100 -> sample 511 still sent with last, then IDLE, busy=0; random fft_data.ready backpressure -> no sample lost or duplicated.
- output of 512 beats with last at beat 511 -> bin_index 0..511, frame_count=1, err_tlast=0; last at beat 510 -> err_tlast=1 and it stays set.
- reset asserted mid-FILL -> all outputs return to reset values immediately; the next enable sends config again.
